// File: rtl/prio_arb_lock_mux.sv
// Registered LSB-first fixed-priority arbiter that locks the grant for a whole
// multi-beat transaction and steers the owner's beats onto one valid/ready channel.
module prio_arb_lock_mux #(
    parameter int SIZE    = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = $clog2(SIZE),
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SIZE-1:0]        req,
    input  logic [SIZE*DATA_W-1:0] req_data,
    input  logic [SIZE-1:0]        req_last,
    output logic [SIZE-1:0]        req_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_last,
    output logic [ID_W-1:0]        out_id,
    output logic [SIZE-1:0]        gnt,
    output logic                   busy,
    output logic                   abort
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t            state, state_next;
    logic [SIZE-1:0]   gnt_next;
    logic [ID_W-1:0]   owner, owner_next, pick;
    logic [CNT_W-1:0]  idle_cnt, cnt_next;
    logic              abort_next;
    logic              any_req;
    logic              owner_req;
    logic              owner_last;
    logic [DATA_W-1:0] data_arr [SIZE];

    for (genvar g = 0; g < SIZE; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    // Descending scan so the lowest set index is the one left standing.
    always_comb begin
        pick    = '0;
        any_req = |req;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (req[i]) pick = ID_W'(i);
        end
    end

    assign owner_req  = req[owner];
    assign owner_last = req_last[owner];

    assign busy      = (state == BUSY);
    assign out_valid = busy & owner_req;
    assign out_last  = busy & owner_last;
    assign out_data  = data_arr[owner];
    assign out_id    = owner;
    // gnt is zero in IDLE, so this also blocks every ready outside BUSY.
    assign req_ready = gnt & {SIZE{out_ready}};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_next = state;
        gnt_next   = gnt;
        owner_next = owner;
        cnt_next   = idle_cnt;
        abort_next = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = BUSY;
                    gnt_next   = SIZE'(1) << pick;
                    owner_next = pick;
                    cnt_next   = '0;
                end
            end
            BUSY: begin
                if (owner_req) begin
                    cnt_next = '0;
                    if (out_ready && owner_last) begin
                        state_next = IDLE;
                        gnt_next   = '0;
                    end
                end else if (idle_cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_next = IDLE;
                    gnt_next   = '0;
                    cnt_next   = '0;
                    abort_next = 1'b1;
                end else begin
                    cnt_next = idle_cnt + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            idle_cnt <= '0;
            abort    <= 1'b0;
        end else begin
            state    <= state_next;
            gnt      <= gnt_next;
            owner    <= owner_next;
            idle_cnt <= cnt_next;
            abort    <= abort_next;
        end
    end

endmodule

// File: tb/tb_prio_arb_lock_mux.sv
// Directed self-checking bench for prio_arb_lock_mux (SIZE=4, DATA_W=32, TIMEOUT=16).
module tb_prio_arb_lock_mux;

    localparam int SIZE    = 4;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [SIZE-1:0]        req;
    logic [SIZE*DATA_W-1:0] req_data;
    logic [SIZE-1:0]        req_last;
    logic [SIZE-1:0]        req_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_W-1:0]      out_data;
    logic                   out_last;
    logic [ID_W-1:0]        out_id;
    logic [SIZE-1:0]        gnt;
    logic                   busy;
    logic                   abort;

    int checks = 0;
    int errors = 0;

    prio_arb_lock_mux #(
        .SIZE(SIZE), .DATA_W(DATA_W), .ID_W(ID_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .out_id(out_id), .gnt(gnt),
        .busy(busy), .abort(abort)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_data(input int idx, input logic [DATA_W-1:0] d);
        req_data[idx*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        rst = 1'b1; req = '0; req_data = '0; req_last = '0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;

        // Idle after reset release
        for (int i = 0; i < 5; i++) begin
            settle();
            check("rst_valid", out_valid, 0);
            check("rst_gnt",   gnt,       0);
            check("rst_busy",  busy,      0);
            if (i == 0) begin
                check("rst_ready", req_ready, 0);
                check("rst_id",    out_id,    0);
                check("rst_abort", abort,     0);
            end
            step();
        end

        // Requester 1 wins over 3, three beats, then 3 is granted after one idle cycle
        req = 4'b1010; out_ready = 1'b1;
        settle();
        check("c0_valid", out_valid, 0);
        check("c0_gnt",   gnt,       0);
        step();
        for (int b = 1; b <= 3; b++) begin
            set_data(1, 32'hA0 + 32'(b));
            req_last[1] = (b == 3);
            settle();
            check("b_gnt",   gnt,       4'b0010);
            check("b_id",    out_id,    1);
            check("b_valid", out_valid, 1);
            check("b_data",  out_data,  32'hA0 + 32'(b));
            check("b_last",  out_last,  (b == 3));
            check("b_ready", req_ready, 4'b0010);
            step();
        end
        req = 4'b1000; req_last = '0;
        settle();
        check("c4_gnt",  gnt,  0);
        check("c4_busy", busy, 0);
        check("c4_ready", req_ready, 0);
        step();
        set_data(3, 32'h33); req_last[3] = 1'b1;
        settle();
        check("c5_gnt",  gnt,      4'b1000);
        check("c5_id",   out_id,   3);
        check("c5_data", out_data, 32'h33);
        step();
        req = '0; req_last = '0;
        settle();
        check("c6_busy", busy, 0);
        step();

        // Owner 2 is not preempted by a later request from 0
        req = 4'b0100; set_data(2, 32'hB1);
        step();
        settle();
        check("p_gnt", gnt, 4'b0100);
        step();
        req = 4'b0101; set_data(2, 32'hB2); set_data(0, 32'hC0);
        settle();
        check("p_gnt2",  gnt,       4'b0100);
        check("p_ready", req_ready, 4'b0100);
        check("p_data",  out_data,  32'hB2);
        step();
        set_data(2, 32'hB3); req_last[2] = 1'b1;
        settle();
        check("p_last_id", out_id,    2);
        check("p_last_rdy", req_ready, 4'b0100);
        step();
        req = 4'b0001; req_last = '0;
        settle();
        check("p_idle_gnt", gnt, 0);
        check("p_idle_valid", out_valid, 0);
        step();
        settle();
        check("p_g0_gnt", gnt,    4'b0001);
        check("p_g0_id",  out_id, 0);

        // Owner 0 under 40 cycles of backpressure: never aborts, data held
        req_last[0] = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            settle();
            check("bp_abort", abort,    0);
            check("bp_busy",  busy,     1);
            check("bp_data",  out_data, 32'hC0);
            step();
        end
        out_ready = 1'b1;
        settle();
        check("bp_ready", req_ready, 4'b0001);
        check("bp_valid", out_valid, 1);
        step();
        req = '0; req_last = '0;
        settle();
        check("bp_done", busy, 0);
        step();

        // Timeout on owner 3, count restarted by a pulse on the 8th idle cycle
        req = 4'b1000; out_ready = 1'b0; set_data(3, 32'h3F);
        step();
        req = '0;
        for (int i = 0; i < 7; i++) begin
            settle();
            check("to_pre_busy", busy, 1);
            step();
        end
        req = 4'b1000;
        step();
        req = '0;
        for (int i = 0; i < TIMEOUT; i++) begin
            settle();
            check("to_busy",  busy,  1);
            check("to_abort", abort, 0);
            step();
        end
        settle();
        check("to_abort_hi", abort,     1);
        check("to_gnt",      gnt,       0);
        check("to_valid",    out_valid, 0);
        step();
        settle();
        check("to_abort_lo", abort, 0);
        step();

        // Reset during beat 2 of 4, then pending req[0] granted one cycle after release
        req = 4'b0001; out_ready = 1'b1; req_last = '0;
        step();
        set_data(0, 32'hD1);
        settle();
        check("rm_b1", out_data, 32'hD1);
        step();
        set_data(0, 32'hD2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        check("rm_gnt",   gnt,       0);
        check("rm_valid", out_valid, 0);
        check("rm_abort", abort,     0);
        check("rm_ready", req_ready, 0);
        step();
        settle();
        check("rm_regnt", gnt, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prio_arb_lock_mux.md
Name: prio_arb_lock_mux

Overview:
- Registered fixed-priority arbiter and data mux that sits directly downstream of the LSB-first priority arbiter logic.
- Arbitrates SIZE multi-beat requesters; bit 0 has the highest priority.
- Locks the grant for the whole transaction, through the beat carrying last.
- Steers the owner's data onto a single valid/ready output channel.

Parameters:
- SIZE, 4, number of requesters (>=2).
- DATA_W, 32, payload width per requester.
- ID_W, $clog2(SIZE), width of out_id.
- TIMEOUT, 16, consecutive owner-idle cycles before forced release (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req  in  SIZE  per-requester valid.
- req_data  in  SIZE*DATA_W  payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  in  SIZE  last beat of the transaction.
- req_ready  out  SIZE  per-requester ready.
- out_valid  out  1  output valid.
- out_ready  in  1  output ready.
- out_data  out  DATA_W  muxed payload.
- out_last  out  1  muxed last.
- out_id  out  ID_W  index of the current owner.
- gnt  out  SIZE  registered one-hot owner; all-zero when IDLE.
- busy  out  1  high in BUSY.
- abort  out  1  one-cycle pulse on timeout release.

Behaviour:
- Reset: synchronous; rst high at a clock edge gives state=IDLE, gnt=0, owner=0, idle_cnt=0, abort=0.
  - Derived outputs after reset: out_valid=0, req_ready=0, busy=0, out_id=0.
- Reset mid-transaction: drop immediately to IDLE. No further beats are sent, and nothing is signalled on abort.
- State IDLE:
  - out_valid=0, req_ready=0.
  - If any req is high, pick the lowest set index k (LSB-first).
  - Next edge: gnt=1<<k, owner=k, state=BUSY, idle_cnt=0.
  - Arbitration latency is 1 cycle: the first beat can transfer in the cycle after req rises.
- State BUSY, owner k:
  - out_valid=req[k]; out_data=req_data[k]; out_last=req_last[k]; out_id=k.
  - req_ready[k]=out_ready; all other req_ready bits are 0.
  - Output fields are combinational from the owner's inputs; no added latency inside BUSY.
- Beat transfer: out_valid & out_ready. If out_last is also high, the next edge goes to IDLE with gnt=0.
- Back-to-back transactions: after release there is always at least one IDLE cycle, so the maximum rate is one transaction per (beats+1) cycles.
- Lock: higher-priority requests arriving during BUSY do not preempt. Re-arbitration happens only in IDLE.
- Timeout:
  - idle_cnt counts consecutive BUSY cycles with req[k]=0. It clears to 0 on any cycle with req[k]=1.
  - When idle_cnt reaches TIMEOUT-1 and req[k] is still 0, the next edge goes to IDLE with gnt=0 and abort=1 for exactly one cycle.
  - out_ready low does not count toward the timeout: backpressure never aborts.
- Simultaneous events: a last-beat transfer in the same cycle as the timeout condition is impossible, because the timeout requires req[k]=0.
- Priority stability: requests in the IDLE cycle use the fixed priority order. Starvation of high indices is permitted by design.
- Widths: idle_cnt is $clog2(TIMEOUT+1) bits and never wraps.

Test Plan:
- Reset release with req=4'b0000 -> out_valid=0, gnt=0, busy=0 held for 5 cycles.
- req=4'b1010 at cycle 0, out_ready=1, requester 1 sends 3 beats (0xA1, 0xA2, 0xA3 with last):
  - gnt=4'b0010 from cycle 1; out_id=1.
  - Data beats in cycles 1-3.
  - Cycle 4 is IDLE; gnt=4'b1000 from cycle 5.
- Owner=2 mid-transaction, req[0] rises -> no preemption; req_ready[0]=0 until owner 2's last beat, then req[0] is granted after one IDLE cycle.
- Owner=0, out_ready=0 for 40 cycles with req[0]=1 -> no abort; out_data held; beat transfers when out_ready rises.
- TIMEOUT=16, owner=3 drops req for 16 cycles -> abort pulse of 1 cycle, gnt=0 in the following cycle. A req[3] pulse at cycle 8 of the idle run resets the count.
- rst asserted during beat 2 of 4 -> next cycle gnt=0, out_valid=0, abort=0. After rst drops, a pending req[0] is granted 1 cycle later.
